par_uart_tx: RTL

Downstream consumer of the parallel output peripheral's `parout_valid`/`parout` byte strobe. It captures each strobed byte into a small FIFO and serialises the bytes onto a single UART-style line: 8N1, LSB first. Buffering lets software issue bytes faster than one UART frame per byte without losing data until the FIFO fills. Overflow is reported through a sticky flag.

---
 rtl/par_uart_pkg.sv | 22 ++
 rtl/par_uart_tx_byte_fifo.sv | 84 ++++++++
 rtl/par_uart_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/par_uart_pkg.sv
// ============================================================================
// Module  : par_uart_pkg
// Brief   : Shared TX state encoding and frame constants for par_uart_tx.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package par_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

endpackage

`default_nettype wire

// File: rtl/par_uart_tx_byte_fifo.sv
// ============================================================================
// Module  : byte_fifo
// Brief   : Power-of-two byte FIFO with combinational head and sticky overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo
  import par_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [7:0]               i_wdata,
  input  logic                     i_ovf_clr,
  output logic [7:0]               o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_ovf
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = c_aw + 1;

  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_lw-1:0] r_level;
  logic            r_ovf;

  logic w_full;
  logic w_empty;
  logic w_rd_en;
  logic w_wr_en;
  logic w_drop;

  assign w_full  = (r_level == c_lw'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_rd_en = i_pop & ~w_empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_wr_en = i_push & (~w_full | w_rd_en);
  assign w_drop  = i_push & w_full & ~w_rd_en;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;
  assign o_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/par_uart_tx.sv
// ============================================================================
// Module  : par_uart_tx
// Brief   : Buffers strobed bytes and serialises them as 8N1, LSB first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module par_uart_tx
  import par_uart_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_i,
  input  logic                   ovf_clr_i,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   ovf_o
);

  localparam int              c_bw        = $clog2(CLKS_PER_BIT);
  localparam logic [c_bw-1:0] c_baud_last = c_bw'(CLKS_PER_BIT - 1);

  tx_state_e       r_state, w_state_nxt;
  logic [c_bw-1:0] r_baud, w_baud_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_tx, w_tx_nxt;
  logic            w_pop;
  logic            w_baud_end;
  logic [7:0]      w_rdata;
  logic            w_empty;
  logic            w_unused_full;
  logic [$clog2(DEPTH):0] w_level;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .i_push    (byte_valid_i),
    .i_pop     (w_pop),
    .i_wdata   (byte_i),
    .i_ovf_clr (ovf_clr_i),
    .o_rdata   (w_rdata),
    .o_full    (w_unused_full),
    .o_empty   (w_empty),
    .o_level   (w_level),
    .o_ovf     (ovf_o)
  );

  assign w_baud_end = (r_baud == c_baud_last);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rdata;
          w_baud_nxt  = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      STOP: begin
        // Chaining straight into START keeps back-to-back frames gap-free.
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_rdata;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign tx_o    = r_tx;
  assign level_o = w_level;
  assign busy_o  = (r_state != IDLE) | (w_level != '0);

endmodule

`default_nettype wire
